// File: rtl/ser_deser_pkg.sv
// ser_deser_pkg: shared FSM state encoding, default word width and counter sizing.
//   SER_DEFAULT_WIDTH : default data word width
//   state_t           : IDLE / SHIFT / PARITY (PARITY used only with SER_PARITY_EN)
//   cnt_width()       : bit-counter width able to hold 0..w
package ser_deser_pkg;
  localparam int SER_DEFAULT_WIDTH = 8;
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SHIFT  = 2'd1;
  localparam state_t PARITY = 2'd2;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: counts sampled bits of the current frame.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count; the count becomes inc (so clear+inc loads 1)
//   inc        : one more bit sampled
//   tc         : terminal count, the next data bit is the last of the word
module ser_bit_counter
  import ser_deser_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);
  localparam int CW = cnt_width(WIDTH);
  logic [CW-1:0] count;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (clear) count <= CW'(inc);
    else if (inc) count <= count + 1'b1;
  assign tc = count == CW'(WIDTH - 1);
endmodule

// File: rtl/ser_deserializer.sv
// ser_deserializer: assembles serial bits into WIDTH-bit words with a one-word output register.
//   clk, reset  : clock, synchronous active-high reset
//   ser_in      : serial data bit, sampled when ser_valid is high
//   frame_start : with ser_valid, current bit is bit 0 of a new frame (aborts any frame in progress)
//   msb_first   : bit order, latched at frame start
//   out_ready   : consumer accepts data_out
//   data_out    : assembled word; data_valid flags an unconsumed word
//   parity_err  : parity mismatch for data_out (0 unless SER_PARITY_EN is defined)
//   overrun     : one-cycle pulse when a completed word is dropped
//   busy        : a frame is in progress
// Optional macro SER_PARITY_EN adds a parity bit after the data bits.
module ser_deserializer
  import ser_deser_pkg::*;
#(
  parameter int WIDTH      = SER_DEFAULT_WIDTH,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             msb_first,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);
`ifdef SER_PARITY_EN
  localparam state_t AFTER_LAST = PARITY;
`else
  localparam state_t AFTER_LAST = IDLE;
`endif
  state_t state;
  logic [WIDTH-1:0] shreg, shifted, first;
  logic msb_q, pend, start, take, tc, done, inc, load;
  assign start = ser_valid & frame_start;
  assign take = ser_valid & ~frame_start;
  assign first = msb_first ? {{(WIDTH-1){1'b0}}, ser_in} : {ser_in, {(WIDTH-1){1'b0}}};
  assign shifted = msb_q ? {shreg[WIDTH-2:0], ser_in} : {ser_in, shreg[WIDTH-1:1]};
`ifdef SER_PARITY_EN
  assign done = take & (state == PARITY);
`else
  assign done = take & (state == SHIFT) & tc;
`endif
  assign inc = start | (take & (state == SHIFT) & ~done);
  // A finished word lands in data_out one edge after completion unless the held word is still unconsumed.
  assign load = pend & ~(data_valid & ~out_ready);
  assign busy = state != IDLE;
  ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(start | done),
    .inc  (inc),
    .tc   (tc)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      msb_q      <= 1'b0;
      pend       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pend    <= done;
      overrun <= pend & data_valid & ~out_ready;
      if (start) begin
        state <= SHIFT;
        shreg <= first;
        msb_q <= msb_first;
      end else if (take && state == SHIFT) begin
        shreg <= shifted;
        if (tc) state <= AFTER_LAST;
      end else if (take && state == PARITY) state <= IDLE;
      if (load) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (out_ready) data_valid <= 1'b0;
    end
`ifdef SER_PARITY_EN
  logic p_bit, perr_q;
  always_ff @(posedge clk)
    if (reset) begin
      p_bit  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (take && state == PARITY) p_bit <= ser_in;
      if (load) perr_q <= ^shreg ^ p_bit ^ PARITY_ODD;
    end
  assign parity_err = perr_q;
`else
  logic unused_par;
  assign unused_par = PARITY_ODD;
  assign parity_err = 1'b0;
`endif
endmodule

// File: doc/ser_deserializer.md
SER_DESERIALIZER -- requirements
Module: ser_deserializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal values are at least 2.
REQ-002 Parameter PARITY_ODD, default 0: parity sense when parity is compiled in; 0 = even, 1 = odd.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 ser_in  input  1  serial data bit.
REQ-006 ser_valid  input  1  ser_in is sampled this cycle; cycles with ser_valid low are ignored.
REQ-007 frame_start  input  1  qualified by ser_valid; marks the current bit as bit 0 of a new frame.
REQ-008 msb_first  input  1  bit order: 1 = MSB first (left shift), 0 = LSB first (right shift).
REQ-009 out_ready  input  1  consumer accepts data_out this cycle.
REQ-010 data_out  output  WIDTH  assembled word, registered.
REQ-011 data_valid  output  1  data_out holds an unconsumed word.
REQ-012 parity_err  output  1  parity mismatch for the word in data_out; tied 0 when parity is compiled out.
REQ-013 overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-014 busy  output  1  a frame is in progress (state is not IDLE).

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, PARITY; PARITY is present only with SER_PARITY_EN.
REQ-016 IDLE: ser_valid and frame_start together SHALL capture ser_in as bit 0, set bit count to 1, latch msb_first for the frame, and go to SHIFT.
REQ-017 IDLE: ser_valid without frame_start SHALL be discarded.
REQ-018 SHIFT, MSB-first, ser_valid: shift register SHALL update to {shreg[WIDTH-2:0], ser_in}.
REQ-019 SHIFT, LSB-first, ser_valid: shift register SHALL update to {ser_in, shreg[WIDTH-1:1]}.
REQ-020 Each SHIFT ser_valid cycle SHALL increment the bit count.
REQ-021 The bit order for a frame SHALL come from the latched msb_first; changes to msb_first mid-frame SHALL have no effect.
REQ-022 SHIFT: ser_valid with frame_start SHALL abort the current frame, produce no output, and restart at bit 0 with the current bit.
REQ-023 Word complete (WIDTH bits received, no parity): FSM SHALL return to IDLE.
REQ-024 On word complete, the word SHALL transfer to data_out with data_valid=1 on the next edge (latency: 1 cycle after the last bit is sampled).
REQ-025 Back-to-back frames SHALL be accepted with no idle cycle between them.
REQ-026 data_out and data_valid SHALL hold until a cycle with out_ready=1, which clears data_valid.
REQ-027 Word completes while data_valid=1 and out_ready=0: the new word SHALL be dropped, data_out unchanged, overrun=1 for one cycle.
REQ-028 Word completes in the same cycle as out_ready=1: data_out SHALL take the new word and data_valid SHALL stay 1.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 On reset the block SHALL go to IDLE with bit count 0 and shift register 0.
REQ-031 On reset data_out, data_valid, parity_err, overrun and busy SHALL all be 0.
REQ-032 A reset mid-frame SHALL discard the partial word with no output.
REQ-033 Reset SHALL take priority over every other input.

Configuration
REQ-034 Macro SER_PARITY_EN defined: after the WIDTH data bits, the next ser_valid bit SHALL be taken as the parity bit in state PARITY.
REQ-035 With SER_PARITY_EN, parity_err SHALL equal (^word ^ parity_bit ^ PARITY_ODD) and SHALL be registered alongside data_out.
REQ-036 With SER_PARITY_EN, the word SHALL be delivered even when parity_err=1.
REQ-037 With SER_PARITY_EN, frame_start in PARITY SHALL abort and restart per REQ-022.
REQ-038 Macro SER_PARITY_EN undefined: no PARITY state and parity_err constant 0.

Structure
REQ-039 Package ser_deser_pkg SHALL hold the FSM state typedef and the default WIDTH constant.
REQ-040 The bit counter SHALL be a sub-module ser_bit_counter with clear, increment, and a terminal-count output.

Verification
REQ-041 MSB-first, bits 0,0,0,1,0,0,1,0 (frame_start on the first) -> data_out=0x12, data_valid=1 one cycle after the 8th bit.
REQ-042 LSB-first, same bit stream -> data_out=0x48.
REQ-043 Same as REQ-041 with 2 ser_valid=0 cycles between each bit -> data_out=0x12, delivered 1 cycle after the last bit.
REQ-044 Two words 0x12 then 0x34 with out_ready=0 -> overrun pulses once, data_out stays 0x12; then out_ready=1 -> data_valid falls.
REQ-045 Reset asserted after 4 bits -> all outputs 0, busy=0; a following frame for 0xA7 -> data_out=0xA7.
REQ-046 SER_PARITY_EN, even parity, 0x12 followed by parity bit 1 -> data_out=0x12, parity_err=1; with parity bit 0 -> parity_err=0.
